mult_issue_sched: RTL and testbench
===================================

# mult_issue_sched

Sequencer and arbiter for the shared iterative multiplier. It takes MUL requests from NREQ issue slots, which are slots whose decoded word asserts the route-to-multiplier control. It grants one request at a time in round-robin order, launches the external multiplier, waits for completion and holds the tagged result on the writeback port until it is accepted. It sits between the issue stage and the multiplier/writeback bus, and it handles pipeline flush.

## Interface
- NREQ, 4, number of requesting issue slots (2..8)
- TAG_W, 6, destination/ROB tag width
- DATA_W, 16, operand and result width
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_vld_in  input  NREQ  bit i: slot i holds a valid MUL request
- req_tag_in  input  NREQ*TAG_W  slot i tag at bits [i*TAG_W +: TAG_W]
- req_opa_in  input  NREQ*DATA_W  slot i operand A, same packing
- req_opb_in  input  NREQ*DATA_W  slot i operand B, same packing
- flush_in  input  1  kill the in-flight and pending operation
- gnt_out  output  NREQ  one-hot grant, combinational; slot i drops its request on the next edge
- busy_out  output  1  high whenever state != IDLE
- mul_start_out  output  1  one-cycle launch pulse to the multiplier
- mul_opa_out, mul_opb_out  output  DATA_W  registered operands, stable from launch until done
- mul_done_in  input  1  multiplier completion pulse
- mul_result_in  input  DATA_W  product low DATA_W bits, valid with mul_done_in
- wb_vld_out  output  1  result valid on the writeback port
- wb_tag_out  output  TAG_W  tag of the result
- wb_data_out  output  DATA_W  result data
- wb_ack_in  input  1  writeback port accepted the result this cycle

## Operation
- States: IDLE, LAUNCH, BUSY, WB.
- IDLE
  - If req_vld_in != 0 and flush_in=0: gnt_out selects the first set bit, searching upward from rr_ptr with wrap.
  - On that edge: latch tag and operands, set rr_ptr to (winner+1) mod NREQ, go to LAUNCH.
  - Otherwise gnt_out=0 and the block stays in IDLE.
- LAUNCH
  - mul_start_out=1 for exactly this cycle.
  - Go to BUSY. mul_done_in is ignored in this state.
- BUSY
  - Wait for mul_done_in=1.
  - On done, capture mul_result_in into the result register.
  - Go to WB, or to IDLE if the killed flag is set.
- WB
  - wb_vld_out=1. Tag and data are held constant until wb_ack_in=1.
  - On ack, go to IDLE.
- Grants are issued only in IDLE. gnt_out is 0 in all other states regardless of requests.
- Flush
  - IDLE: no grant that cycle.
  - LAUNCH or BUSY: set the killed flag, and let the multiplier finish, since it cannot be aborted. On done, discard the result, clear the flag and go to IDLE. wb_vld_out never asserts for a killed operation.
  - WB: drop the result, go to IDLE next cycle; wb_vld_out deasserts next cycle.
  - A flush in the same cycle as wb_ack_in counts as accepted. The next state is IDLE either way.
- No arithmetic is done in this block. Widths pass straight through, with no truncation beyond the multiplier's low DATA_W bits.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, rr_ptr=0, killed=0.
  - gnt_out, busy_out, mul_start_out, wb_vld_out = 0.
  - mul_opa_out, mul_opb_out, wb_tag_out, wb_data_out = 0.
- Reset mid-operation abandons the operation. Any later mul_done_in is ignored while in IDLE.
- Cycle T: grant, in IDLE.
- T+1: LAUNCH, mul_start_out=1, operands valid.
- T+2 onward: BUSY.
- If mul_done_in arrives at cycle D ≥ T+2, wb_vld_out=1 from D+1.
- Minimum grant-to-writeback latency is 3 cycles.
- After ack at cycle A, the earliest next grant is A+1.
- The next launch is therefore at A+2, which gives a back-to-back throughput of one operation per (multiplier latency + 3) cycles.
- busy_out is high from T+1 through the cycle of the ack or discard.

## Test plan
- Single request: slot 2 requests at cycle 1 with tag 0x15, A=0x0003, B=0x0007, and the model returns done 4 cycles after start with 0x0015. Required: gnt_out=0100 at cycle 1, start at cycle 2, wb_vld/tag 0x15/data 0x0015 from cycle 7, held through a 2-cycle ack delay.
- Round robin: all 4 slots request continuously with immediate ack. Required: grant order 0,1,2,3,0, with no grant outside IDLE.
- Sparse fairness: slots 1 and 3 request, rr_ptr=2. Required: grants go to 3, then 1, then 3.
- Flush in BUSY: flush one cycle after start. Required: after done the block returns to IDLE with wb_vld_out never high, and the next request is granted normally.
- Flush in WB: flush while wb_vld_out=1 and ack=0. Required: wb_vld_out=0 next cycle, state IDLE. A flush in IDLE together with a request must produce gnt_out=0.
- Reset mid-operation: assert rst_n=0 during BUSY, then deliver a stale mul_done_in after release. Required: all outputs 0, no writeback, next grant from slot 0.

Source files
------------

// File: rtl/mult_issue_sched_if.sv
// Bundle of the issue-slot request bus, multiplier launch/complete signals and
// the writeback port around the shared multiplier scheduler.
interface mult_issue_sched_if #(
   parameter int NREQ   = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 16
);
   logic [NREQ-1:0]        req_vld_in;
   logic [NREQ*TAG_W-1:0]  req_tag_in;
   logic [NREQ*DATA_W-1:0] req_opa_in;
   logic [NREQ*DATA_W-1:0] req_opb_in;
   logic                   flush_in;
   logic [NREQ-1:0]        gnt_out;
   logic                   busy_out;
   logic                   mul_start_out;
   logic [DATA_W-1:0]      mul_opa_out;
   logic [DATA_W-1:0]      mul_opb_out;
   logic                   mul_done_in;
   logic [DATA_W-1:0]      mul_result_in;
   logic                   wb_vld_out;
   logic [TAG_W-1:0]       wb_tag_out;
   logic [DATA_W-1:0]      wb_data_out;
   logic                   wb_ack_in;

   modport slave (
      input  req_vld_in, req_tag_in, req_opa_in, req_opb_in, flush_in,
      input  mul_done_in, mul_result_in, wb_ack_in,
      output gnt_out, busy_out, mul_start_out, mul_opa_out, mul_opb_out,
      output wb_vld_out, wb_tag_out, wb_data_out
   );

   modport master (
      output req_vld_in, req_tag_in, req_opa_in, req_opb_in, flush_in,
      output mul_done_in, mul_result_in, wb_ack_in,
      input  gnt_out, busy_out, mul_start_out, mul_opa_out, mul_opb_out,
      input  wb_vld_out, wb_tag_out, wb_data_out
   );
endinterface

// File: rtl/mult_issue_sched.sv
// Round-robin arbiter and sequencer for the shared iterative multiplier.
//  state  | meaning
//  IDLE   | arbitrate requests, grant one, latch its tag/operands
//  LAUNCH | one-cycle start pulse to the multiplier
//  BUSY   | wait for multiplier done; discard result if flushed
//  WB     | hold tagged result on writeback port until ack or flush
module mult_issue_sched #(
   parameter int NREQ   = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 16
) (
   input logic clk,
   input logic rst_n,
   mult_issue_sched_if.slave bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_BUSY, ST_WB} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              killed_q, killed_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [PTR_W-1:0]  win;
   logic              found;
   logic [NREQ-1:0]   gnt;

   // first requesting slot at or above rr_ptr, wrapping at NREQ
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req_vld_in[idx]) begin
            found = 1'b1;
            win   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      killed_d = killed_q;
      tag_d    = tag_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      gnt      = '0;
      case (state_q)
         ST_IDLE: begin
            killed_d = 1'b0;
            if (found && !bus.flush_in) begin
               gnt[win] = 1'b1;
               tag_d    = bus.req_tag_in[int'(win)*TAG_W +: TAG_W];
               opa_d    = bus.req_opa_in[int'(win)*DATA_W +: DATA_W];
               opb_d    = bus.req_opb_in[int'(win)*DATA_W +: DATA_W];
               rr_ptr_d = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
               state_d  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (bus.flush_in) killed_d = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (bus.flush_in) killed_d = 1'b1;
            // the multiplier cannot be aborted, so a killed op still waits for done
            if (bus.mul_done_in) begin
               if (killed_q || bus.flush_in) begin
                  killed_d = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  res_d   = bus.mul_result_in;
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            if (bus.wb_ack_in || bus.flush_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         killed_q <= 1'b0;
         tag_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         killed_q <= killed_d;
         tag_q    <= tag_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
      end
   end

   assign bus.gnt_out       = gnt;
   assign bus.busy_out      = (state_q != ST_IDLE);
   assign bus.mul_start_out = (state_q == ST_LAUNCH);
   assign bus.mul_opa_out   = opa_q;
   assign bus.mul_opb_out   = opb_q;
   assign bus.wb_vld_out    = (state_q == ST_WB);
   assign bus.wb_tag_out    = tag_q;
   assign bus.wb_data_out   = res_q;
endmodule

// File: tb/tb_mult_issue_sched.sv
// Scoreboard bench for mult_issue_sched with a fixed-latency multiplier model.
module tb_mult_issue_sched;
   localparam int NREQ = 4, TAG_W = 6, DATA_W = 16, LAT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_issue_sched_if #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) ifc ();
   mult_issue_sched #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
   );

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   int ack_dly = 0, wb_wait = 0;
   logic [TAG_W-1:0]  tag_a[NREQ];
   logic [DATA_W-1:0] opa_a[NREQ], opb_a[NREQ];

   // multiplier model: done LAT cycles after the start cycle
   int mcnt = 0;
   logic [DATA_W-1:0] mprod = '0;
   always @(negedge clk) begin
      ifc.mul_done_in = 1'b0;
      if (ifc.mul_start_out) begin
         mcnt  = LAT;
         mprod = ifc.mul_opa_out * ifc.mul_opb_out;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) ifc.mul_done_in = 1'b1;
      end
      ifc.mul_result_in = ifc.mul_done_in ? mprod : 16'hdead;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_slots();
      for (int i = 0; i < NREQ; i++) begin
         ifc.req_tag_in[i*TAG_W +: TAG_W]   = tag_a[i];
         ifc.req_opa_in[i*DATA_W +: DATA_W] = opa_a[i];
         ifc.req_opb_in[i*DATA_W +: DATA_W] = opb_a[i];
      end
   endtask

   function automatic logic [DATA_W-1:0] prod16(input int i);
      logic [2*DATA_W-1:0] p;
      p = opa_a[i] * opb_a[i];
      return p[DATA_W-1:0];
   endfunction

   // advance one cycle; writeback monitor compares against scoreboard head
   task automatic tick();
      @(negedge clk);
      if (ifc.wb_vld_out) begin
         if (sb.size() == 0) chk("wb_unexpected", 1, 0);
         else begin
            chk("wb_tag", ifc.wb_tag_out, sb[0].tag);
            chk("wb_data", ifc.wb_data_out, sb[0].data);
         end
         if (wb_wait >= ack_dly) begin
            ifc.wb_ack_in = 1'b1;
            if (sb.size() != 0) void'(sb.pop_front());
            wb_wait = 0;
         end else begin
            ifc.wb_ack_in = 1'b0;
            wb_wait++;
         end
      end else begin
         ifc.wb_ack_in = 1'b0;
         wb_wait = 0;
      end
   endtask

   task automatic do_op(input logic [NREQ-1:0] mask, input int w, input int dly, input bit keep);
      exp_t e;
      int n;
      ack_dly = dly;
      ifc.req_vld_in = mask;
      #1;
      chk("gnt", ifc.gnt_out, 32'(1) << w);
      e.tag = tag_a[w];
      e.data = prod16(w);
      sb.push_back(e);
      tick();
      if (!keep) ifc.req_vld_in[w] = 1'b0;
      #1;
      chk("start", ifc.mul_start_out, 1);
      chk("opa", ifc.mul_opa_out, opa_a[w]);
      chk("opb", ifc.mul_opb_out, opb_a[w]);
      chk("no_gnt_launch", ifc.gnt_out, 0);
      n = 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (!ifc.busy_out) begin
            n = c;
            break;
         end
         chk("no_gnt_busy", ifc.gnt_out, 0);
         chk("start_once", ifc.mul_start_out, 0);
         chk("wb_vld_win", ifc.wb_vld_out, (c >= LAT + 1 && c <= LAT + 1 + dly));
         if (c <= LAT) chk("opa_hold", ifc.mul_opa_out, opa_a[w]);
      end
      chk("lat", n, LAT + 2 + dly);
   endtask

   initial begin
      int n;
      bit seen;
      exp_t e;
      ifc.req_vld_in = '0;
      ifc.flush_in   = 1'b0;
      ifc.wb_ack_in  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         tag_a[i] = TAG_W'(6'h20 + i);
         opa_a[i] = DATA_W'($urandom);
         opb_a[i] = DATA_W'($urandom);
      end
      tag_a[2] = 6'h15; opa_a[2] = 16'h0003; opb_a[2] = 16'h0007;
      drive_slots();
      repeat (3) tick();
      chk("rst_gnt", ifc.gnt_out, 0);
      chk("rst_busy", ifc.busy_out, 0);
      chk("rst_start", ifc.mul_start_out, 0);
      chk("rst_wbvld", ifc.wb_vld_out, 0);
      chk("rst_opa", ifc.mul_opa_out, 0);
      chk("rst_opb", ifc.mul_opb_out, 0);
      chk("rst_tag", ifc.wb_tag_out, 0);
      chk("rst_data", ifc.wb_data_out, 0);
      rst_n = 1'b1;
      tick();

      // single request, slot 2, 2-cycle ack delay
      do_op(4'b0100, 2, 2, 1'b0);
      do_op(4'b1000, 3, 0, 1'b0);
      // continuous round robin from rr_ptr=0
      do_op(4'b1111, 0, 0, 1'b1);
      do_op(4'b1111, 1, 0, 1'b1);
      do_op(4'b1111, 2, 0, 1'b1);
      do_op(4'b1111, 3, 0, 1'b1);
      do_op(4'b1111, 0, 0, 1'b1);
      do_op(4'b0010, 1, 0, 1'b0);
      // sparse fairness from rr_ptr=2
      do_op(4'b1010, 3, 0, 1'b0);
      do_op(4'b1010, 1, 0, 1'b0);
      do_op(4'b1010, 3, 0, 1'b0);
      ifc.req_vld_in = '0;

      // flush one cycle after start
      ifc.req_vld_in = 4'b0001;
      #1 chk("fb_gnt", ifc.gnt_out, 4'b0001);
      tick();
      ifc.req_vld_in = '0;
      chk("fb_start", ifc.mul_start_out, 1);
      tick();
      ifc.flush_in = 1'b1;
      tick();
      ifc.flush_in = 1'b0;
      n = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk("fb_no_wb", ifc.wb_vld_out, 0);
         if (!ifc.busy_out) begin
            n = c;
            break;
         end
      end
      chk("fb_idle_lat", n, 3);
      do_op(4'b0001, 0, 0, 1'b0);

      // flush while result waits for ack
      ifc.req_vld_in = 4'b0100;
      ack_dly = 100;
      #1 chk("fw_gnt", ifc.gnt_out, 4'b0100);
      e.tag = tag_a[2];
      e.data = prod16(2);
      sb.push_back(e);
      tick();
      ifc.req_vld_in = '0;
      seen = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (ifc.wb_vld_out) begin
            seen = 1'b1;
            break;
         end
      end
      chk("fw_reach_wb", seen, 1);
      ifc.flush_in = 1'b1;
      tick();
      ifc.flush_in = 1'b0;
      chk("fw_vld_drop", ifc.wb_vld_out, 0);
      chk("fw_idle", ifc.busy_out, 0);
      if (sb.size() != 0) void'(sb.pop_front());
      ack_dly = 0;

      // flush in IDLE blocks the grant
      ifc.flush_in = 1'b1;
      ifc.req_vld_in = 4'b0010;
      #1 chk("fi_gnt", ifc.gnt_out, 0);
      tick();
      chk("fi_idle", ifc.busy_out, 0);
      ifc.flush_in = 1'b0;
      do_op(4'b0010, 1, 0, 1'b0);

      // reset during BUSY, stale done afterwards
      ifc.req_vld_in = 4'b0010;
      #1 chk("rm_gnt", ifc.gnt_out, 4'b0010);
      tick();
      ifc.req_vld_in = '0;
      tick();
      chk("rm_in_busy", ifc.busy_out, 1);
      rst_n = 1'b0;
      #1;
      chk("rm_busy", ifc.busy_out, 0);
      chk("rm_start", ifc.mul_start_out, 0);
      chk("rm_wbvld", ifc.wb_vld_out, 0);
      chk("rm_opa", ifc.mul_opa_out, 0);
      chk("rm_opb", ifc.mul_opb_out, 0);
      chk("rm_tag", ifc.wb_tag_out, 0);
      chk("rm_data", ifc.wb_data_out, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk("rm_stale_busy", ifc.busy_out, 0);
         chk("rm_stale_wb", ifc.wb_vld_out, 0);
      end
      do_op(4'b1111, 0, 0, 1'b0);
      ifc.req_vld_in = '0;
      tick();
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
